// File: rtl/fb_pkg.sv
// Shared types, scan states and size helpers for the frame-buffer scan reader.
package fb_pkg;

  typedef logic [2:0] scan_state_t;

  localparam scan_state_t ST_IDLE   = 3'd0;
  localparam scan_state_t ST_RD_TOP = 3'd1;
  localparam scan_state_t ST_RD_BOT = 3'd2;
  localparam scan_state_t ST_CAP    = 3'd3;
  localparam scan_state_t ST_OUT    = 3'd4;

  function automatic int unsigned line_len(input int unsigned width, input int unsigned chained);
    return width * chained;
  endfunction

  // Offset from a top-half pixel to its bottom-half partner.
  function automatic int unsigned half_len(input int unsigned width, input int unsigned chained,
                                           input int unsigned height);
    return line_len(width, chained) * (height / 2);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit addr_fits(input int unsigned addr_w, input int unsigned width,
                                   input int unsigned chained, input int unsigned height,
                                   input bit dbl);
    longint unsigned need;
    longint unsigned cap;
    need = longint'(line_len(width, chained)) * longint'(height) * (dbl ? 64'd2 : 64'd1);
    cap  = 64'd1 << addr_w;
    return cap >= need;
  endfunction

endpackage

// File: rtl/fb_scan_reader_if.sv
// Memory read port and pixel-pair stream between the scan reader and its neighbours.
interface fb_scan_reader_if #(
  parameter int unsigned BPP    = 12,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned COL_W  = 7,
  parameter int unsigned ROW_W  = 5
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [BPP-1:0]    mem_dat;
  logic [BPP-1:0]    pix_top;
  logic [BPP-1:0]    pix_bot;
  logic [COL_W-1:0]  pix_col;
  logic [ROW_W-1:0]  pix_row;
  logic              pix_valid;
  logic              pix_ready;
  logic              line_done;
  logic              frame_done;

  modport master (
    output mem_addr, mem_re, pix_top, pix_bot, pix_col, pix_row, pix_valid, line_done, frame_done,
    input  mem_dat, pix_ready
  );

  modport slave (
    input  mem_addr, mem_re, pix_top, pix_bot, pix_col, pix_row, pix_valid, line_done, frame_done,
    output mem_dat, pix_ready
  );
endinterface

// File: rtl/fb_scan_counter.sv
// Column/row/top-address counters for the HUB75 scan walk, with wrap and last-position flags.
module fb_scan_counter
  import fb_pkg::*;
#(
  parameter int unsigned LINE   = 128,
  parameter int unsigned ROWS   = 32,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned COL_W  = cnt_width(LINE),
  parameter int unsigned ROW_W  = cnt_width(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_base,
  output logic [COL_W-1:0]  o_col,
  output logic [ROW_W-1:0]  o_row,
  output logic [ADDR_W-1:0] o_top_nxt_c,
  output logic              o_last_col_c,
  output logic              o_last_row_c
);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_top;
  logic [COL_W-1:0]  w_col_nxt;
  logic [ROW_W-1:0]  w_row_nxt;
  logic [ADDR_W-1:0] w_top_nxt;

  assign o_last_col_c = (r_col == COL_W'(LINE - 1));
  assign o_last_row_c = (r_row == ROW_W'(ROWS - 1));

  // Clear (frame start / abort) wins over an accepted-pair increment.
  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    w_top_nxt = r_top;
    if (i_clr) begin
      w_col_nxt = '0;
      w_row_nxt = '0;
      w_top_nxt = i_base;
    end else if (i_inc) begin
      w_top_nxt = r_top + ADDR_W'(1);
      if (o_last_col_c) begin
        w_col_nxt = '0;
        w_row_nxt = o_last_row_c ? '0 : r_row + ROW_W'(1);
      end else begin
        w_col_nxt = r_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_top <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      r_top <= w_top_nxt;
    end
  end

  assign o_col       = r_col;
  assign o_row       = r_row;
  assign o_top_nxt_c = w_top_nxt;

endmodule

// File: rtl/fb_scan_reader.sv
// Port-B read sequencer walking the frame in HUB75 order and emitting top/bottom pixel pairs.
// Optional FB_SCAN_DOUBLE_BUFFER_EN adds swap_req/disp_buf for ping-pong frame buffers.
module fb_scan_reader
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned HEIGHT  = 64,
  parameter int unsigned BPP     = 12,
  parameter int unsigned CHAINED = 1,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  fb_scan_reader_if.master  bus,
  input  logic              start,
  input  logic              stop,
  input  logic              cont_mode,
  output logic              busy
`ifdef FB_SCAN_DOUBLE_BUFFER_EN
  ,
  input  logic              swap_req,
  output logic              disp_buf
`endif
);

  localparam int unsigned LINE  = line_len(WIDTH, CHAINED);
  localparam int unsigned ROWS  = HEIGHT / 2;
  localparam int unsigned HALF  = half_len(WIDTH, CHAINED, HEIGHT);
  localparam int unsigned COL_W = cnt_width(LINE);
  localparam int unsigned ROW_W = cnt_width(ROWS);
`ifdef FB_SCAN_DOUBLE_BUFFER_EN
  localparam bit          DBL   = 1'b1;
  localparam int unsigned FRAME = LINE * HEIGHT;
`else
  localparam bit          DBL   = 1'b0;
`endif

  if (!addr_fits(ADDR_W, WIDTH, CHAINED, HEIGHT, DBL) || (HEIGHT % 2) != 0) begin : g_cfg_err
    $error("fb_scan_reader: ADDR_W too small for the frame or HEIGHT is odd");
  end

  scan_state_t       r_state;
  scan_state_t       w_state_nxt;
  logic              w_clr;
  logic              w_inc;
  logic              w_accept;
  logic              w_frame_end;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_top_nxt;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic              w_last_col;
  logic              w_last_row;

  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_re;
  logic [BPP-1:0]    r_pix_top;
  logic [BPP-1:0]    r_pix_bot;
  logic [COL_W-1:0]  r_pix_col;
  logic [ROW_W-1:0]  r_pix_row;
  logic              r_pix_valid;
  logic              r_line_done;
  logic              r_frame_done;
  logic              r_busy;

  assign w_accept    = (r_state == ST_OUT) && bus.pix_ready && !stop;
  assign w_frame_end = w_accept && w_last_col && w_last_row;

`ifdef FB_SCAN_DOUBLE_BUFFER_EN
  logic r_disp_buf;
  logic w_disp_nxt;

  // The toggle lands on the same edge as the frame-end clear, so the next frame starts on the new buffer.
  assign w_disp_nxt = r_disp_buf ^ (w_frame_end && swap_req);
  assign w_base     = w_disp_nxt ? ADDR_W'(FRAME) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_disp_buf <= 1'b0;
    else     r_disp_buf <= w_disp_nxt;
  end

  assign disp_buf = r_disp_buf;
`else
  assign w_base = '0;
`endif

  fb_scan_counter #(
    .LINE   (LINE),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_inc        (w_inc),
    .i_base       (w_base),
    .o_col        (w_col),
    .o_row        (w_row),
    .o_top_nxt_c  (w_top_nxt),
    .o_last_col_c (w_last_col),
    .o_last_row_c (w_last_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and counter control; stop overrides start and acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    if (stop) begin
      w_state_nxt = ST_IDLE;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_RD_TOP;
            w_clr       = 1'b1;
          end
        end
        ST_RD_TOP: w_state_nxt = ST_RD_BOT;
        ST_RD_BOT: w_state_nxt = ST_CAP;
        ST_CAP:    w_state_nxt = ST_OUT;
        ST_OUT: begin
          if (bus.pix_ready) begin
            w_inc = 1'b1;
            if (w_frame_end) begin
              w_clr       = 1'b1;
              w_state_nxt = cont_mode ? ST_RD_TOP : ST_IDLE;
            end else begin
              w_state_nxt = ST_RD_TOP;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered off the next state so mem_re/mem_addr are valid during RD_TOP/RD_BOT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr   <= '0;
      r_mem_re     <= 1'b0;
      r_pix_top    <= '0;
      r_pix_bot    <= '0;
      r_pix_col    <= '0;
      r_pix_row    <= '0;
      r_pix_valid  <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_mem_re     <= (w_state_nxt == ST_RD_TOP) || (w_state_nxt == ST_RD_BOT);
      r_mem_addr   <= (w_state_nxt == ST_RD_BOT) ? w_top_nxt + ADDR_W'(HALF) : w_top_nxt;
      r_pix_valid  <= (w_state_nxt == ST_OUT);
      r_line_done  <= w_accept && w_last_col;
      r_frame_done <= w_frame_end;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_RD_BOT) r_pix_top <= bus.mem_dat;
      if (r_state == ST_CAP) begin
        r_pix_bot <= bus.mem_dat;
        r_pix_col <= w_col;
        r_pix_row <= w_row;
      end
    end
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_re     = r_mem_re;
  assign bus.pix_top    = r_pix_top;
  assign bus.pix_bot    = r_pix_bot;
  assign bus.pix_col    = r_pix_col;
  assign bus.pix_row    = r_pix_row;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.line_done  = r_line_done;
  assign bus.frame_done = r_frame_done;
  assign busy           = r_busy;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Scoreboard bench for fb_scan_reader on a 4x4 panel with a mem[i]=i frame memory.
module tb_fb_scan_reader;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned HEIGHT = 4;
  localparam int unsigned BPP    = 12;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned COL_W  = 2;
  localparam int unsigned ROW_W  = 1;
  localparam int          HALF   = 8;
  localparam int          NPAIR  = 8;

  typedef struct packed {
    logic [BPP-1:0]   top;
    logic [BPP-1:0]   bot;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic cont_mode = 1'b0;
  logic busy;
`ifdef FB_SCAN_DOUBLE_BUFFER_EN
  logic swap_req = 1'b0;
  logic disp_buf;
`endif

  fb_scan_reader_if #(.BPP(BPP), .ADDR_W(ADDR_W), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  fb_scan_reader #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPP(BPP), .CHAINED(1), .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .start     (start),
    .stop      (stop),
    .cont_mode (cont_mode),
    .busy      (busy)
`ifdef FB_SCAN_DOUBLE_BUFFER_EN
    ,
    .swap_req  (swap_req),
    .disp_buf  (disp_buf)
`endif
  );

  always #5 clk = ~clk;

  logic [BPP-1:0] mem [32];
  always @(posedge clk) if (bus.mem_re) bus.mem_dat <= mem[bus.mem_addr];

  pair_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int                line_at[$];
  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int line_cnt = 0;
  int frame_cnt = 0;

  function automatic pair_t mk(input int idx, input int base);
    pair_t p;
    p.top = BPP'(base + idx);
    p.bot = BPP'(base + idx + HALF);
    p.col = COL_W'(idx % 4);
    p.row = ROW_W'(idx / 4);
    return p;
  endfunction

  task automatic push_frame(input int base);
    for (int i = 0; i < NPAIR; i++) exp_q.push_back(mk(i, base));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard: pops one expected pair per accepted handshake; logs reads and done pulses.
  task automatic monitor();
    pair_t got, want;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_re) addr_q.push_back(bus.mem_addr);
        if (bus.line_done) begin
          line_cnt++;
          line_at.push_back(acc_cnt);
        end
        if (bus.frame_done) frame_cnt++;
        if (bus.pix_valid && bus.pix_ready && !stop) begin
          acc_cnt++;
          got.top = bus.pix_top;
          got.bot = bus.pix_bot;
          got.col = bus.pix_col;
          got.row = bus.pix_row;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pair: unexpected pair top=%0d bot=%0d col=%0d row=%0d at %0t",
                     got.top, got.bot, got.col, got.row, $time);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL pair: got top=%0d bot=%0d col=%0d row=%0d, expected top=%0d bot=%0d col=%0d row=%0d",
                       got.top, got.bot, got.col, got.row, want.top, want.bot, want.col, want.row);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_read(input int addr, input string tag);
    int n = 0;
    while (!(bus.mem_re === 1'b1 && bus.mem_addr === ADDR_W'(addr)) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s: timeout waiting for read of address %0d", tag, addr);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.pix_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s: timeout waiting for pix_valid", tag);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: timeout waiting for busy to drop", tag);
    end
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    rst = 1'b1;
    #3;
    outs = 64'({bus.mem_addr, bus.mem_re, bus.pix_top, bus.pix_bot, bus.pix_col, bus.pix_row,
                bus.pix_valid, bus.line_done, bus.frame_done});
    checks++;
    if (outs !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: got 0x%0h, expected 0", outs);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int  l0 = line_cnt;
    int  f0 = frame_cnt;
    int  a0 = acc_cnt;
    bit  bad;
    addr_q.delete();
    line_at.delete();
    push_frame(0);
    bus.pix_ready = 1'b1;
    cont_mode = 1'b0;
    pulse_start();
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== ADDR_W'(0) || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_read: mem_re=%b addr=%0d busy=%b, expected 1/0/1", bus.mem_re, bus.mem_addr, busy);
    end
    wait_idle("single_frame");
    tick();
    checks++;
    if (exp_q.size() != 0 || acc_cnt - a0 != NPAIR) begin
      errors++;
      $display("FAIL single_count: accepted %0d, %0d left, expected 8 accepted 0 left", acc_cnt - a0, exp_q.size());
    end
    checks++;
    if (line_cnt - l0 != 2 || line_at.size() != 2 || line_at[0] != a0 + 4 || line_at[1] != a0 + 8) begin
      errors++;
      $display("FAIL single_line_done: %0d pulses, expected 2 after pairs 4 and 8", line_cnt - l0);
    end
    checks++;
    if (frame_cnt - f0 != 1) begin
      errors++;
      $display("FAIL single_frame_done: %0d pulses, expected 1", frame_cnt - f0);
    end
    bad = (addr_q.size() != 2 * NPAIR);
    for (int i = 0; i < 2 * NPAIR && !bad; i++)
      if (addr_q[i] !== ADDR_W'(i / 2 + (i % 2) * HALF)) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL read_order: %0d reads logged, expected 16 reads 0,8,1,9,..,7,15", addr_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    push_frame(0);
    bus.pix_ready = 1'b1;
    pulse_start();
    wait_read(2, "bp_read");
    bus.pix_ready = 1'b0;
    wait_valid("bp_valid");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_top !== BPP'(2) || bus.pix_bot !== BPP'(10) || bus.pix_col !== COL_W'(2)) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b top=%0d bot=%0d col=%0d, expected 1/2/10/2",
                 k, bus.pix_valid, bus.pix_top, bus.pix_bot, bus.pix_col);
      end
      tick();
    end
    bus.pix_ready = 1'b1;
    tick();
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.mem_re !== 1'b1 || bus.mem_addr !== ADDR_W'(3)) begin
      errors++;
      $display("FAIL bp_release: valid=%b mem_re=%b addr=%0d, expected 0/1/3", bus.pix_valid, bus.mem_re, bus.mem_addr);
    end
    wait_idle("bp_done");
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d pairs left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_cont_mode();
    int f0 = frame_cnt;
    int l0 = line_cnt;
    int a0 = acc_cnt;
    int n  = 0;
    push_frame(0);
    push_frame(0);
    cont_mode = 1'b1;
    bus.pix_ready = 1'b1;
    pulse_start();
    while (busy === 1'b1 && n < 400) begin
      if (n == 20) start = 1'b1;
      if (n == 21) start = 1'b0;
      if (frame_cnt - f0 >= 1) cont_mode = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    checks++;
    if (acc_cnt - a0 != 2 * NPAIR) begin
      errors++;
      $display("FAIL cont_busy: busy dropped after %0d pairs, expected 16", acc_cnt - a0);
    end
    tick();
    checks++;
    if (frame_cnt - f0 != 2 || line_cnt - l0 != 4) begin
      errors++;
      $display("FAIL cont_done: frame_done=%0d line_done=%0d, expected 2 and 4", frame_cnt - f0, line_cnt - l0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_drain: %0d pairs left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stop();
    int f0 = frame_cnt;
    int l0 = line_cnt;
    int a0 = acc_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(i, 0));
    bus.pix_ready = 1'b1;
    pulse_start();
    wait_read(5, "stop_read");
    bus.pix_ready = 1'b0;
    wait_valid("stop_valid");
    checks++;
    if (bus.pix_top !== BPP'(5) || bus.pix_bot !== BPP'(13)) begin
      errors++;
      $display("FAIL stop_pair: top=%0d bot=%0d, expected 5/13", bus.pix_top, bus.pix_bot);
    end
    stop = 1'b1;
    bus.pix_ready = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (bus.pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: valid=%b busy=%b, expected 0/0", bus.pix_valid, busy);
    end
    tick();
    tick();
    tick();
    checks++;
    if (frame_cnt - f0 != 0 || line_cnt - l0 != 1 || acc_cnt - a0 != 5) begin
      errors++;
      $display("FAIL stop_pulses: frame=%0d line=%0d accepted=%0d, expected 0/1/5",
               frame_cnt - f0, line_cnt - l0, acc_cnt - a0);
    end
    push_frame(0);
    pulse_start();
    wait_idle("stop_restart");
    tick();
    checks++;
    if (exp_q.size() != 0 || frame_cnt - f0 != 1) begin
      errors++;
      $display("FAIL stop_restart: %0d left frame_done=%0d, expected 0/1", exp_q.size(), frame_cnt - f0);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] outs;
    exp_q.delete();
    bus.pix_ready = 1'b1;
    pulse_start();
    wait_read(HALF, "areset_read");
    #2;
    rst = 1'b1;
    #1;
    outs = 64'({bus.mem_addr, bus.mem_re, bus.pix_top, bus.pix_bot, bus.pix_col, bus.pix_row,
                bus.pix_valid, bus.line_done, bus.frame_done, busy});
    checks++;
    if (outs !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: outputs 0x%0h before clock edge, expected 0", outs);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || bus.mem_re !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_idle: busy=%b mem_re=%b, expected 0/0", busy, bus.mem_re);
    end
  endtask

`ifdef FB_SCAN_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    int f0 = frame_cnt;
    int n  = 0;
    bit bad;
    checks++;
    if (disp_buf !== 1'b0) begin
      errors++;
      $display("FAIL db_initial: disp_buf=%b, expected 0", disp_buf);
    end
    addr_q.delete();
    push_frame(0);
    push_frame(16);
    swap_req = 1'b1;
    cont_mode = 1'b1;
    bus.pix_ready = 1'b1;
    pulse_start();
    while (busy === 1'b1 && n < 400) begin
      if (frame_cnt - f0 >= 1) begin
        swap_req = 1'b0;
        cont_mode = 1'b0;
      end
      tick();
      n++;
    end
    tick();
    bad = (addr_q.size() != 4 * NPAIR);
    for (int i = 0; i < 4 * NPAIR && !bad; i++)
      if (addr_q[i] !== ADDR_W'((i / 16) * 16 + (i % 16) / 2 + (i % 2) * HALF)) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL db_reads: %0d reads logged, expected 0..15 then 16..31 in pair order", addr_q.size());
    end
    checks++;
    if (disp_buf !== 1'b1 || frame_cnt - f0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL db_swap: disp_buf=%b frames=%0d left=%0d, expected 1/2/0", disp_buf, frame_cnt - f0, exp_q.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = BPP'(i);
    bus.pix_ready = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_frame();
    test_backpressure();
    test_cont_mode();
    test_stop();
    test_async_reset();
`ifdef FB_SCAN_DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
